ct_merge_rr: RTL and testbench

- Packet-aware round-robin merge node. It shares one downstream link (typically a field-conversion stage followed by a crossbar port) among NI upstream requesters.
- Once a requester wins, it holds the grant until its end-of-packet beat transfers. Packets are therefore never interleaved.
- One registered output stage. Streams keep full throughput with valid/ready backpressure.

---
 rtl/ct_merge_rr_pkg.sv | 14 +
 rtl/ct_rr_pick.sv | 33 +++
 rtl/ct_merge_rr.sv | 113 +++++++++++
 tb/tb_ct_merge_rr.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ct_merge_rr_pkg.sv
// Shared types and helpers for the ct merge/arbitration nodes.
package ct_pkg;

  typedef enum logic {
    CT_IDLE = 1'b0,
    CT_LOCK = 1'b1
  } ct_state_e;

  // Index width that never collapses to zero bits.
  function automatic int ct_clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ct_rr_pick.sv
// Combinational rotate-priority picker: first asserted req scanning ptr, ptr+1, ... mod NI.
module ct_rr_pick
  import ct_pkg::*;
#(
  parameter int NI = 2,
  parameter int WS = ct_clog2_min1(NI)
) (
  input  logic [NI-1:0] req,
  input  logic [WS-1:0] ptr,
  output logic [WS-1:0] grant,
  output logic          grant_vld
);

  logic [2*NI-1:0] dbl;
  logic [WS:0]     idx;

  // Rotate req so bit 0 is the pointed-to port, then take the lowest set bit.
  always_comb begin
    dbl       = {req, req} >> ptr;
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int i = 0; i < NI; i++) begin
      idx = {1'b0, ptr} + (WS+1)'(i);
      if (idx >= (WS+1)'(NI)) idx = idx - (WS+1)'(NI);
      if (!grant_vld && dbl[i]) begin
        grant_vld = 1'b1;
        grant     = idx[WS-1:0];
      end
    end
  end

endmodule

// File: rtl/ct_merge_rr.sv
// Packet-aware round-robin merge with one registered output stage.
//
// Handshake: a beat moves across an interface in any cycle where valid and
// ready are both high. Upstream ready (o_ready) is combinational and only
// ever asserted for the granted port; valid must not depend on ready.
module ct_merge_rr
  import ct_pkg::*;
#(
  parameter int NI = 2,
  parameter int WD = 8,
  parameter int WF = 2,
  parameter int WS = ct_clog2_min1(NI)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NI*WD-1:0] i_data,
  input  logic [NI*WF-1:0] i_field,
  input  logic [NI-1:0]    i_eop,
  input  logic [NI-1:0]    i_valid,
  output logic [NI-1:0]    o_ready,
  output logic [WD-1:0]    o_data,
  output logic [WF-1:0]    o_field,
  output logic             o_eop,
  output logic [WS-1:0]    o_sel,
  output logic             o_valid,
  input  logic             i_ready,
  output ct_state_e        dbg_state
);

  if (NI < 2) begin : g_bad_ni
    $error("ct_merge_rr: NI must be >= 2");
  end

  ct_state_e   state, state_n;
  logic [WS-1:0] ptr, ptr_n, lock_idx, lock_n;
  logic [WS-1:0] pick, grant, grant_inc;
  logic          pick_vld, grant_vld, load, xfer;

  assign dbg_state = state;

  ct_rr_pick #(.NI(NI), .WS(WS)) u_pick (
    .req       (i_valid),
    .ptr       (ptr),
    .grant     (pick),
    .grant_vld (pick_vld)
  );

  // Grant selection, upstream ready and the pointer-after-grant value.
  always_comb begin
    load      = !o_valid || i_ready;
    grant     = (state == CT_IDLE) ? pick : lock_idx;
    grant_vld = (state == CT_IDLE) ? pick_vld : i_valid[lock_idx];
    o_ready   = '0;
    if (load && grant_vld && !reset) o_ready[grant] = 1'b1;
    xfer      = |(i_valid & o_ready);
    grant_inc = (grant == WS'(NI-1)) ? '0 : grant + 1'b1;
  end

  // Next-state: lock on a non-final beat, release and advance ptr on eop.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    lock_n  = lock_idx;
    if (xfer) begin
      if (i_eop[grant]) begin
        state_n = CT_IDLE;
        ptr_n   = grant_inc;
      end else begin
        state_n = CT_LOCK;
        lock_n  = grant;
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CT_IDLE;
      ptr      <= '0;
      lock_idx <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      lock_idx <= lock_n;
    end
  end

  // Output stage: load on transfer, drain on downstream accept, else hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_field <= '0;
      o_eop   <= 1'b0;
      o_sel   <= '0;
    end else if (xfer) begin
      o_valid <= 1'b1;
      o_data  <= i_data[WD*grant +: WD];
      o_field <= i_field[WF*grant +: WF];
      o_eop   <= i_eop[grant];
      o_sel   <= grant;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

  a_hold: assert property (@(posedge clk) disable iff (reset)
    (o_valid && !i_ready) |=> $stable({o_data, o_field, o_eop, o_sel}));

  a_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(o_ready));

endmodule

// File: tb/tb_ct_merge_rr.sv
// Directed bench for ct_merge_rr: NI=2 vector table plus an NI=3 wrap sequence.
module tb_ct_merge_rr;
  import ct_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- NI=2 instance ----------------
  logic [15:0] i_data;
  logic [3:0]  i_field;
  logic [1:0]  i_eop, i_valid, o_ready;
  logic [7:0]  o_data;
  logic [1:0]  o_field;
  logic        o_eop, o_valid, i_ready;
  logic [0:0]  o_sel;
  ct_state_e   dbg_state;

  ct_merge_rr #(.NI(2), .WD(8), .WF(2)) dut (
    .clk(clk), .reset(reset), .i_data(i_data), .i_field(i_field),
    .i_eop(i_eop), .i_valid(i_valid), .o_ready(o_ready), .o_data(o_data),
    .o_field(o_field), .o_eop(o_eop), .o_sel(o_sel), .o_valid(o_valid),
    .i_ready(i_ready), .dbg_state(dbg_state)
  );

  // ---------------- NI=3 instance ----------------
  logic [23:0] w_i_data;
  logic [5:0]  w_i_field;
  logic [2:0]  w_i_eop, w_i_valid, w_o_ready;
  logic [7:0]  w_o_data;
  logic [1:0]  w_o_field, w_o_sel;
  logic        w_o_eop, w_o_valid, w_i_ready;
  ct_state_e   w_dbg_state;

  ct_merge_rr #(.NI(3), .WD(8), .WF(2)) dut3 (
    .clk(clk), .reset(reset), .i_data(w_i_data), .i_field(w_i_field),
    .i_eop(w_i_eop), .i_valid(w_i_valid), .o_ready(w_o_ready), .o_data(w_o_data),
    .o_field(w_o_field), .o_eop(w_o_eop), .o_sel(w_o_sel), .o_valid(w_o_valid),
    .i_ready(w_i_ready), .dbg_state(w_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] valid;
    logic [1:0] eop;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       rdy;
    logic [1:0] e_ready;
    logic       e_valid;
    logic       e_sel;
    logic [7:0] e_data;
    logic       e_eop;
  } vec_t;

  vec_t vecs[19];

  task automatic fill_vectors();
    // round robin, single-beat packets on both ports
    vecs[0]  = '{2'b11, 2'b11, 8'h01, 8'h81, 1'b1, 2'b01, 1'b1, 1'b0, 8'h01, 1'b1};
    vecs[1]  = '{2'b11, 2'b11, 8'h02, 8'h82, 1'b1, 2'b10, 1'b1, 1'b1, 8'h82, 1'b1};
    vecs[2]  = '{2'b11, 2'b11, 8'h03, 8'h83, 1'b1, 2'b01, 1'b1, 1'b0, 8'h03, 1'b1};
    vecs[3]  = '{2'b11, 2'b11, 8'h04, 8'h84, 1'b1, 2'b10, 1'b1, 1'b1, 8'h84, 1'b1};
    // port0 3-beat packet while port1 waits
    vecs[4]  = '{2'b11, 2'b10, 8'h11, 8'h91, 1'b1, 2'b01, 1'b1, 1'b0, 8'h11, 1'b0};
    vecs[5]  = '{2'b11, 2'b10, 8'h12, 8'h92, 1'b1, 2'b01, 1'b1, 1'b0, 8'h12, 1'b0};
    vecs[6]  = '{2'b11, 2'b11, 8'h13, 8'h93, 1'b1, 2'b01, 1'b1, 1'b0, 8'h13, 1'b1};
    vecs[7]  = '{2'b11, 2'b11, 8'h14, 8'h94, 1'b1, 2'b10, 1'b1, 1'b1, 8'h94, 1'b1};
    // backpressure: A5 held for 4 stalled cycles
    vecs[8]  = '{2'b01, 2'b01, 8'hA5, 8'h00, 1'b1, 2'b01, 1'b1, 1'b0, 8'hA5, 1'b1};
    vecs[9]  = '{2'b11, 2'b11, 8'h5A, 8'h3C, 1'b0, 2'b00, 1'b1, 1'b0, 8'hA5, 1'b1};
    vecs[10] = '{2'b11, 2'b11, 8'h5A, 8'h3C, 1'b0, 2'b00, 1'b1, 1'b0, 8'hA5, 1'b1};
    vecs[11] = '{2'b11, 2'b11, 8'h5A, 8'h3C, 1'b0, 2'b00, 1'b1, 1'b0, 8'hA5, 1'b1};
    vecs[12] = '{2'b11, 2'b11, 8'h5A, 8'h3C, 1'b0, 2'b00, 1'b1, 1'b0, 8'hA5, 1'b1};
    vecs[13] = '{2'b11, 2'b11, 8'h5A, 8'h3C, 1'b1, 2'b10, 1'b1, 1'b1, 8'h3C, 1'b1};
    // bubble inside a 2-beat lock on port0
    vecs[14] = '{2'b11, 2'b10, 8'h21, 8'hB1, 1'b1, 2'b01, 1'b1, 1'b0, 8'h21, 1'b0};
    vecs[15] = '{2'b10, 2'b10, 8'h00, 8'hB2, 1'b1, 2'b00, 1'b0, 1'b0, 8'h21, 1'b0};
    vecs[16] = '{2'b10, 2'b10, 8'h00, 8'hB3, 1'b1, 2'b00, 1'b0, 1'b0, 8'h21, 1'b0};
    vecs[17] = '{2'b11, 2'b11, 8'h22, 8'hB4, 1'b1, 2'b01, 1'b1, 1'b0, 8'h22, 1'b1};
    vecs[18] = '{2'b10, 2'b10, 8'h00, 8'hB5, 1'b1, 2'b10, 1'b1, 1'b1, 8'hB5, 1'b1};
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_vec(input vec_t v, input int n);
    @(negedge clk);
    reset   = 1'b0;
    i_valid = v.valid;
    i_eop   = v.eop;
    i_data  = {v.d1, v.d0};
    i_ready = v.rdy;
    #1;
    check($sformatf("v%0d o_ready", n), 32'(o_ready), 32'(v.e_ready));
    @(posedge clk);
    #1;
    check($sformatf("v%0d o_valid", n), 32'(o_valid), 32'(v.e_valid));
    check($sformatf("v%0d o_sel", n),   32'(o_sel),   32'(v.e_sel));
    check($sformatf("v%0d o_data", n),  32'(o_data),  32'(v.e_data));
    check($sformatf("v%0d o_eop", n),   32'(o_eop),   32'(v.e_eop));
    check($sformatf("v%0d o_field", n), 32'(o_field), v.e_sel ? 32'h2 : 32'h1);
  endtask

  task automatic w_drive(input logic [2:0] valid);
    @(negedge clk);
    w_i_valid = valid;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    i_valid = 2'b11; i_eop = 2'b11; i_data = 16'h0; i_ready = 1'b1;
    i_field = {2'b10, 2'b01};
    w_i_valid = 3'b000; w_i_eop = 3'b111; w_i_ready = 1'b1;
    w_i_data = {8'h32, 8'h31, 8'h30};
    w_i_field = {2'b11, 2'b10, 2'b01};
    fill_vectors();

    // reset held 3 cycles with all inputs valid
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("rst o_ready",   32'(o_ready),   32'h0);
      check("rst o_valid",   32'(o_valid),   32'h0);
      check("rst o_sel",     32'(o_sel),     32'h0);
      check("rst w_o_ready", 32'(w_o_ready), 32'h0);
    end

    for (int n = 0; n < 19; n++) apply_vec(vecs[n], n);

    // NI=3 wrap: one port0 beat moves ptr to 1, then ports 0 and 2 alternate
    w_drive(3'b001);
    #1 check("w first o_ready", 32'(w_o_ready), 32'h1);
    @(posedge clk); #1;
    check("w first o_sel", 32'(w_o_sel), 32'h0);
    exp_q.push_back(2'd2); exp_q.push_back(2'd0);
    exp_q.push_back(2'd2); exp_q.push_back(2'd0);
    for (int k = 0; k < 4; k++) begin
      logic [1:0] e;
      e = exp_q.pop_front();
      w_drive(3'b101);
      #1 check($sformatf("w%0d o_ready", k), 32'(w_o_ready), 32'(1) << e);
      @(posedge clk); #1;
      check($sformatf("w%0d o_valid", k), 32'(w_o_valid), 32'h1);
      check($sformatf("w%0d o_sel", k),   32'(w_o_sel),   32'(e));
      check($sformatf("w%0d o_data", k),  32'(w_o_data),  32'h30 + 32'(e));
    end
    check("w queue drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
